// File: rtl/demux_frame_collector.sv
// demux_frame_collector: serial bits fanned out to eight registered channels o1..o8; `DEMUX_PARITY_EN adds an even-parity check bit.
// Latency: o1..o8 and frame_valid register one cycle after the last bit of a frame is accepted.
// Backpressure: a_ready drops while a completed frame waits; frame_ready reopens it in that same cycle (no bubble).
module demux_frame_collector (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic a,
    input  logic a_valid,
    output logic a_ready,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic o8,
    output logic frame_valid,
    input  logic frame_ready
`ifdef DEMUX_PARITY_EN
    ,
    output logic parity_err
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
`ifdef DEMUX_PARITY_EN
        PARITY  = 2'd1,
`endif
        FULL    = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  ptr, ptr_nxt;
    logic [7:0]  stage, stage_nxt;
    logic [7:0]  frame, frame_nxt;
    logic        fv_nxt;
    logic        accept;
`ifdef DEMUX_PARITY_EN
    logic        pe_q, pe_nxt;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        stage_nxt = stage;
        frame_nxt = frame;
        fv_nxt    = frame_valid;
`ifdef DEMUX_PARITY_EN
        pe_nxt    = pe_q;
`endif
        a_ready   = (state == FULL) ? frame_ready : 1'b1;
        accept    = a_valid && a_ready;

        if (clr) begin
            state_nxt = COLLECT;
            ptr_nxt   = 3'd0;
            stage_nxt = 8'd0;
            frame_nxt = 8'd0;
            fv_nxt    = 1'b0;
`ifdef DEMUX_PARITY_EN
            pe_nxt    = 1'b0;
`endif
        end else begin
            if (accept) begin
                stage_nxt[ptr] = a;
                ptr_nxt        = ptr + 3'd1;
            end
            case (state)
                COLLECT: begin
                    if (accept && ptr == 3'd7) begin
`ifdef DEMUX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = FULL;
                        frame_nxt = stage_nxt;
                        fv_nxt    = 1'b1;
`endif
                    end
                end
`ifdef DEMUX_PARITY_EN
                PARITY: begin
                    // The parity bit is checked, never staged; pointer parks at 0.
                    ptr_nxt   = ptr;
                    stage_nxt = stage;
                    if (accept) begin
                        state_nxt = FULL;
                        frame_nxt = stage;
                        fv_nxt    = 1'b1;
                        pe_nxt    = ^{stage, a};
                    end
                end
`endif
                FULL: begin
                    // A bit accepted here already landed in stage[0] as o1 of the next frame.
                    if (frame_ready) begin
                        state_nxt = COLLECT;
                        fv_nxt    = 1'b0;
                    end
                end
                default: state_nxt = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            ptr         <= 3'd0;
            stage       <= 8'd0;
            frame       <= 8'd0;
            frame_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
            pe_q        <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            stage       <= stage_nxt;
            frame       <= frame_nxt;
            frame_valid <= fv_nxt;
`ifdef DEMUX_PARITY_EN
            pe_q        <= pe_nxt;
`endif
        end
    end

    assign {s1, s2, s3} = ptr;
    assign {o8, o7, o6, o5, o4, o3, o2, o1} = frame;
`ifdef DEMUX_PARITY_EN
    assign parity_err = pe_q;
`endif

endmodule

// File: doc/demux_frame_collector.md
DEMUX_FRAME_COLLECTOR -- requirements
Module: demux_frame_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk  input  1  clock, rising edge active
  rst_n  input  1  async reset, active low
  clr  input  1  sync clear of frame in progress
  a  input  1  serial data bit
  a_valid  input  1  a carries a bit this cycle
  a_ready  output  1  block accepts a this cycle
  s1  output  1  channel pointer MSB
  s2  output  1  channel pointer mid bit
  s3  output  1  channel pointer LSB
  o1..o8  output  1 each  registered frame channels; o1 = first bit received
  frame_valid  output  1  o1..o8 hold a complete frame
  frame_ready  input  1  downstream consumes the frame
  parity_err  output  1  parity mismatch (only with DEMUX_PARITY_EN)

Function
REQ-003 An input bit SHALL be accepted only on a rising clk edge where a_valid=1 and a_ready=1.
REQ-004 The 3-bit pointer {s1,s2,s3} SHALL give the channel of the next accepted bit: value 0 = o1 ... value 7 = o8.
REQ-005 An accepted data bit SHALL be written to an internal staging bit at the pointer index, and the pointer SHALL increment by 1, modulo 8.
REQ-006 The FSM SHALL have the states COLLECT, PARITY (DEMUX_PARITY_EN only) and FULL.
REQ-007 COLLECT: a_ready=1; the 8th accepted bit (pointer 7 -> 0) SHALL move to PARITY if enabled, else to FULL.
REQ-008 The move to FULL SHALL, on that same edge, load o1..o8 from the staging bits (including the bit accepted on that edge) and set frame_valid=1.
REQ-009 Latency SHALL be one cycle: frame_valid is high in the cycle after the final bit is accepted.
REQ-010 FULL: o1..o8 and frame_valid SHALL hold until frame_ready=1; a_ready = frame_ready.
REQ-011 In FULL with frame_ready=1, the frame SHALL be consumed: frame_valid drops next cycle and the state returns to COLLECT.
REQ-012 If a_valid=1 in that same consume cycle, the bit SHALL be accepted as channel o1 of the next frame, so that back-to-back frames have no bubble.
REQ-013 o1..o8 SHALL change only on frame completion; during collection they SHALL retain the last completed frame.
REQ-014 a_valid without a_ready SHALL have no effect; the bit is not lost to the source, which holds it.
REQ-015 clr=1 SHALL, on the next edge and with priority over all other inputs:
  - clear the pointer, staging bits, o1..o8, frame_valid and parity_err to 0;
  - enter COLLECT;
  - discard any bit presented in that cycle.
REQ-016 frame_ready while frame_valid=0 SHALL be ignored.

Reset
REQ-017 rst_n=0 SHALL immediately, independent of clk, set:
  - the state to COLLECT;
  - {s1,s2,s3}=0, staging bits=0, o1..o8=0;
  - frame_valid=0, parity_err=0, a_ready=1.
REQ-018 A partial frame in progress at reset SHALL be discarded; the first bit accepted after rst_n rises SHALL be o1.

Configuration
REQ-019 Macro DEMUX_PARITY_EN SHALL compile in even-parity checking.
REQ-020 With DEMUX_PARITY_EN defined:
  - PARITY has a_ready=1 and accepts a 9th bit (the parity bit), then moves to FULL, loading o1..o8 per REQ-008;
  - the pointer stays at 0 during PARITY;
  - parity_err SHALL be registered with frame_valid as XOR(o1..o8, parity bit), and hold with the frame.
REQ-021 Without DEMUX_PARITY_EN, the PARITY state and the parity_err port SHALL be absent, and frames SHALL be 8 bits.

Verification
REQ-022 Reset: drive rst_n=0 mid-frame after 3 bits, then release -> all outputs 0 asynchronously and a_ready=1; the next 8 bits 11111111 give o1..o8 all 1.
REQ-023 Single frame: send 1,0,1,1,0,0,1,0 with frame_ready=0 -> the next cycle gives o1..o8=1,0,1,1,0,0,1,0, frame_valid=1 and a_ready=0, held for 10 cycles.
REQ-024 Streaming: frame_ready=1 and a_valid=1 continuously for 24 bits (no parity) -> frame_valid pulses for 1 cycle every 8 cycles, and a_ready never drops.
REQ-025 Clear: send 5 bits, then clr=1 for 1 cycle, then 00000001 -> o8=1, o1..o7=0, and the pointer reads 0 after clr.
REQ-026 Backpressure: a_valid toggling 1,0,1,0 across 16 cycles -> a single frame completes after the 8th accepted bit, and the pointer holds on idle cycles.
REQ-027 Parity (DEMUX_PARITY_EN): data 11100000 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1; frame_valid is asserted only after the 9th bit.
